fpu_issue_ctrl: RTL and testbench

// - Requester/consumer end of the FPU request/result handshake. Accepts FP commands from decode and

---
 rtl/fpu_issue_ctrl_pkg.sv | 25 ++
 rtl/fpu_issue_ctrl_rob_slots.sv | 57 +++++
 rtl/fpu_issue_ctrl.sv | 99 +++++++++
 tb/tb_fpu_issue_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: FPU command control and status types shared by the issue controller and its reorder slots
package fpu_issue_ctrl_pkg;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;
  typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM, DYN = 3'b111} roundmode_e;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
  typedef status_t fpu_status_t;
  typedef struct packed {
    operation_e  op;
    logic        op_mod;
    roundmode_e  rnd_mode;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
  } fpu_cmd_ctrl_t;
endpackage

// File: rtl/fpu_issue_ctrl_rob_slots.sv
// fpu_rob_slots: reorder slot array holding alloc/done flags, destination register and captured result
module fpu_rob_slots
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NUM_TAGS = 4,
  localparam int IDX_W   = $clog2(NUM_TAGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                alloc_i,
  input  logic [IDX_W-1:0]    alloc_idx_i,
  input  logic [4:0]          alloc_rd_i,
  input  logic                cap_i,
  input  logic [IDX_W-1:0]    cap_idx_i,
  input  logic [WIDTH-1:0]    cap_result_i,
  input  fpu_status_t         cap_status_i,
  input  logic                ret_i,
  input  logic [IDX_W-1:0]    head_idx_i,
  output logic [NUM_TAGS-1:0] alloc_o,
  output logic [NUM_TAGS-1:0] done_o,
  output logic [4:0]          head_rd_o,
  output logic [WIDTH-1:0]    head_result_o,
  output fpu_status_t         head_status_o
);
  logic [4:0]       rd_q  [NUM_TAGS];
  logic [WIDTH-1:0] res_q [NUM_TAGS];
  fpu_status_t      st_q  [NUM_TAGS];
  // Caller guarantees alloc, capture and retire target distinct slots in one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      alloc_o <= '0;
      done_o  <= '0;
    end else begin
      if (alloc_i) begin
        alloc_o[alloc_idx_i] <= 1'b1;
        done_o[alloc_idx_i]  <= 1'b0;
      end
      if (cap_i) done_o[cap_idx_i] <= 1'b1;
      if (ret_i) begin
        alloc_o[head_idx_i] <= 1'b0;
        done_o[head_idx_i]  <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (alloc_i) rd_q[alloc_idx_i] <= alloc_rd_i;
    if (cap_i) begin
      res_q[cap_idx_i] <= cap_result_i;
      st_q[cap_idx_i]  <= cap_status_i;
    end
  end
  assign head_rd_o     = rd_q[head_idx_i];
  assign head_result_o = res_q[head_idx_i];
  assign head_status_o = st_q[head_idx_i];
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: tags FP commands with epoch/slot, issues them to the FPU and retires results in program order
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NUM_TAGS = 4,
  localparam int IDX_W   = $clog2(NUM_TAGS),
  localparam int TAG_W   = IDX_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0][WIDTH-1:0] cmd_operands_i,
  input  fpu_cmd_ctrl_t         cmd_ctrl_i,
  input  logic [4:0]            cmd_rd_i,
  output logic                  fpu_in_valid_o,
  input  logic                  fpu_in_ready_i,
  output logic [2:0][WIDTH-1:0] fpu_operands_o,
  output fpu_cmd_ctrl_t         fpu_ctrl_o,
  output logic [TAG_W-1:0]      fpu_tag_o,
  output logic                  fpu_flush_o,
  input  logic                  fpu_out_valid_i,
  output logic                  fpu_out_ready_o,
  input  logic [WIDTH-1:0]      fpu_result_i,
  input  fpu_status_t           fpu_status_i,
  input  logic [TAG_W-1:0]      fpu_tag_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [WIDTH-1:0]      wb_result_o,
  output fpu_status_t           wb_status_o,
  output logic [4:0]            wb_rd_o,
  output logic                  busy_o,
  output logic                  stale_drop_o,
  output logic                  err_o
);
  logic [IDX_W-1:0]    head_q, tail_q;
  logic [TAG_W-1:0]    count_q;
  logic                epoch_q;
  logic [NUM_TAGS-1:0] alloc, done;
  logic                full, issue, retire, same_ep, cap_ok, cap;
  logic [IDX_W-1:0]    cap_idx;
  assign full            = count_q == TAG_W'(NUM_TAGS);
  assign fpu_in_valid_o  = cmd_valid_i & ~full & ~flush_i & ~rst_i;
  assign issue           = fpu_in_valid_o & fpu_in_ready_i;
  assign cmd_ready_o     = issue;
  assign fpu_operands_o  = cmd_operands_i;
  assign fpu_ctrl_o      = cmd_ctrl_i;
  assign fpu_tag_o       = {epoch_q, tail_q};
  assign fpu_flush_o     = flush_i;
  assign fpu_out_ready_o = 1'b1;
  assign cap_idx         = fpu_tag_i[IDX_W-1:0];
  assign same_ep         = fpu_tag_i[IDX_W] == epoch_q;
  assign cap_ok          = alloc[cap_idx] & ~done[cap_idx];
  assign cap             = fpu_out_valid_i & same_ep & cap_ok & ~flush_i & ~rst_i;
  assign stale_drop_o    = fpu_out_valid_i & ~same_ep & ~rst_i;
  assign err_o           = fpu_out_valid_i & same_ep & ~cap_ok & ~rst_i;
  assign wb_valid_o      = done[head_q] & ~flush_i & ~rst_i;
  assign retire          = wb_valid_o & wb_ready_i;
  assign busy_o          = (count_q != '0) & ~rst_i;
  // Flush toggles the epoch so results still in the FPU pipe are recognised as stale
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= 1'b0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= ~epoch_q;
    end else begin
      head_q  <= head_q + IDX_W'(retire);
      tail_q  <= tail_q + IDX_W'(issue);
      count_q <= count_q + TAG_W'(issue) - TAG_W'(retire);
    end
  end
  fpu_rob_slots #(.WIDTH(WIDTH), .NUM_TAGS(NUM_TAGS)) u_slots (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (flush_i),
    .alloc_i      (issue),
    .alloc_idx_i  (tail_q),
    .alloc_rd_i   (cmd_rd_i),
    .cap_i        (cap),
    .cap_idx_i    (cap_idx),
    .cap_result_i (fpu_result_i),
    .cap_status_i (fpu_status_i),
    .ret_i        (retire),
    .head_idx_i   (head_q),
    .alloc_o      (alloc),
    .done_o       (done),
    .head_rd_o    (wb_rd_o),
    .head_result_o(wb_result_o),
    .head_status_o(wb_status_o)
  );
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed self-checking bench for the FPU issue/reorder controller
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;
  logic              clk = 1'b0;
  logic              rst, flush, cmd_valid, cmd_ready;
  logic [2:0][63:0]  cmd_ops, fpu_ops;
  fpu_cmd_ctrl_t     cmd_ctrl, fpu_ctrl;
  logic [4:0]        cmd_rd, wb_rd;
  logic              fpu_in_valid, fpu_in_ready, fpu_flush, fpu_out_valid, fpu_out_ready;
  logic [2:0]        fpu_tag_o, fpu_tag_i;
  logic [63:0]       fpu_result, wb_result;
  fpu_status_t       fpu_status, wb_status;
  logic              wb_valid, wb_ready, busy, stale, err;
  int                n_cmp = 0;
  int                n_bad = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.WIDTH(64), .NUM_TAGS(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_operands_i(cmd_ops),
    .cmd_ctrl_i(cmd_ctrl), .cmd_rd_i(cmd_rd),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready), .fpu_operands_o(fpu_ops),
    .fpu_ctrl_o(fpu_ctrl), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready), .fpu_result_i(fpu_result),
    .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_i),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
    .wb_status_o(wb_status), .wb_rd_o(wb_rd),
    .busy_o(busy), .stale_drop_o(stale), .err_o(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic result(input logic v, input logic [2:0] t, input logic [63:0] r);
    fpu_out_valid = v;
    fpu_tag_i = t;
    fpu_result = r;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b1; cmd_rd = 5'd0; fpu_in_ready = 1'b1;
    cmd_ops = '0; cmd_ctrl = '0; fpu_status = '0; wb_ready = 1'b0;
    result(1'b0, 3'd0, 64'd0);
    tick(); tick(); settle();
    check("rst_in_valid", fpu_in_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_ready", fpu_out_ready, 1);
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    // single ADD
    cmd_valid = 1'b1; cmd_rd = 5'd3; cmd_ctrl.op = ADD; cmd_ops[1] = 64'h1234; settle();
    check("add_ready", cmd_ready, 1);
    check("add_tag", fpu_tag_o, 3'b000);
    check("add_fwd_ops", fpu_ops[1], 64'h1234);
    tick(); cmd_valid = 1'b0; settle();
    check("add_busy", busy, 1);
    check("add_wb_early", wb_valid, 0);
    tick(); result(1'b1, 3'b000, 64'h4000000000000000); fpu_status = 5'b00001; settle();
    check("add_wb_same_cycle", wb_valid, 0);
    tick(); result(1'b0, 3'd0, 64'd0); fpu_status = '0; wb_ready = 1'b1; settle();
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_rd", wb_rd, 3);
    check("add_wb_result", wb_result, 64'h4000000000000000);
    check("add_wb_status", wb_status, 5'b00001);
    tick(); wb_ready = 1'b0; settle();
    check("add_wb_done", wb_valid, 0);
    check("add_idle", busy, 0);
    // four issues starting at slot 1, results out of order
    cmd_valid = 1'b1; cmd_rd = 5'd10; settle(); check("ooo_tag0", fpu_tag_o, 3'b001);
    tick(); cmd_rd = 5'd11; settle(); check("ooo_tag1", fpu_tag_o, 3'b010);
    tick(); cmd_rd = 5'd12; settle(); check("ooo_tag2", fpu_tag_o, 3'b011);
    tick(); cmd_rd = 5'd13; settle(); check("ooo_tag3", fpu_tag_o, 3'b000);
    check("ooo_ready3", cmd_ready, 1);
    tick(); cmd_rd = 5'd14; settle();
    check("full_in_valid", fpu_in_valid, 0);
    check("full_ready", cmd_ready, 0);
    cmd_valid = 1'b0; wb_ready = 1'b1; result(1'b1, 3'b011, 64'd112); settle();
    check("ooo_a_wb", wb_valid, 0);
    tick(); result(1'b1, 3'b001, 64'd110); settle();
    check("ooo_b_wb", wb_valid, 0);
    tick(); result(1'b1, 3'b000, 64'd113); settle();
    check("ooo_c_wb", wb_valid, 1);
    check("ooo_c_rd", wb_rd, 10);
    check("ooo_c_res", wb_result, 110);
    tick(); result(1'b1, 3'b010, 64'd111); settle();
    check("ooo_d_wb", wb_valid, 0);
    tick(); result(1'b0, 3'd0, 64'd0); settle();
    check("ooo_e_rd", wb_rd, 11);
    check("ooo_e_res", wb_result, 111);
    check("ooo_e_wb", wb_valid, 1);
    tick(); settle();
    check("ooo_f_wb", wb_valid, 1);
    check("ooo_f_rd", wb_rd, 12);
    tick(); settle();
    check("ooo_g_wb", wb_valid, 1);
    check("ooo_g_rd", wb_rd, 13);
    check("ooo_g_res", wb_result, 113);
    tick(); wb_ready = 1'b0; settle();
    check("ooo_h_wb", wb_valid, 0);
    check("ooo_h_busy", busy, 0);
    // flush with three in flight
    cmd_valid = 1'b1; cmd_rd = 5'd5; tick(); cmd_rd = 5'd6; tick(); cmd_rd = 5'd7; settle();
    check("fl_tag3", fpu_tag_o, 3'b011);
    tick(); flush = 1'b1; cmd_rd = 5'd8; settle();
    check("fl_flush_o", fpu_flush, 1);
    check("fl_in_valid", fpu_in_valid, 0);
    check("fl_ready", cmd_ready, 0);
    tick(); flush = 1'b0; cmd_valid = 1'b0; result(1'b1, 3'b001, 64'd99); settle();
    check("fl_stale", stale, 1);
    check("fl_err", err, 0);
    check("fl_busy", busy, 0);
    check("fl_wb", wb_valid, 0);
    check("fl_new_tag", fpu_tag_o, 3'b100);
    check("fl_flush_clr", fpu_flush, 0);
    tick(); result(1'b0, 3'd0, 64'd0); settle();
    check("fl_stale_clr", stale, 0);
    check("fl_wb_after", wb_valid, 0);
    // fill in epoch 1, then retire and allocate together
    cmd_valid = 1'b1; cmd_rd = 5'd20; settle(); check("fill_tag0", fpu_tag_o, 3'b100);
    tick(); cmd_rd = 5'd21; tick(); cmd_rd = 5'd22; tick(); cmd_rd = 5'd23; settle();
    check("fill_tag3", fpu_tag_o, 3'b111);
    tick(); cmd_rd = 5'd24; result(1'b1, 3'b100, 64'hAA); settle();
    check("fill_full_ready", cmd_ready, 0);
    tick(); result(1'b0, 3'd0, 64'd0); wb_ready = 1'b1; settle();
    check("fill_wb_valid", wb_valid, 1);
    check("fill_wb_rd", wb_rd, 20);
    check("fill_same_cycle_ready", cmd_ready, 0);
    tick(); wb_ready = 1'b0; settle();
    check("fill_next_ready", cmd_ready, 1);
    check("fill_wrap_tag", fpu_tag_o, 3'b100);
    check("fill_wb_clr", wb_valid, 0);
    tick(); cmd_valid = 1'b0; settle();
    check("fill_busy", busy, 1);
    // error cases
    result(1'b1, 3'b101, 64'h11); settle();
    check("err_first_ok", err, 0);
    check("err_first_stale", stale, 0);
    tick(); result(1'b1, 3'b101, 64'h22); settle();
    check("err_dup", err, 1);
    check("err_dup_wb", wb_valid, 1);
    check("err_dup_res", wb_result, 64'h11);
    tick(); result(1'b0, 3'd0, 64'd0); settle();
    check("err_dup_unchanged", wb_result, 64'h11);
    check("err_dup_rd", wb_rd, 21);
    check("err_clr", err, 0);
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0; result(1'b1, 3'b101, 64'h33); settle();
    check("err_unalloc", err, 1);
    tick(); result(1'b0, 3'd0, 64'd0); settle();
    check("err_unalloc_wb", wb_valid, 0);
    check("err_unalloc_busy", busy, 1);
    // reset mid-stream
    rst = 1'b1; cmd_valid = 1'b1; cmd_rd = 5'd9; wb_ready = 1'b1; result(1'b1, 3'b000, 64'd1); settle();
    check("mrst_in_valid", fpu_in_valid, 0);
    check("mrst_ready", cmd_ready, 0);
    check("mrst_wb", wb_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_err", err, 0);
    check("mrst_stale", stale, 0);
    tick(); rst = 1'b0; result(1'b0, 3'd0, 64'd0); settle();
    check("mrst_busy_after", busy, 0);
    check("mrst_wb_after", wb_valid, 0);
    check("mrst_tag", fpu_tag_o, 3'b000);
    check("mrst_ready_after", cmd_ready, 1);
    tick(); cmd_valid = 1'b0; settle();
    check("mrst_issue_busy", busy, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
